// File: rtl/truth_table_sequencer.sv
// Sweeps {w,x,y,z} over NUM_ROWS rows, samples f_in SETTLE_CYCLES edges into each row, and emits one row per valid/ready transfer.
// Throughput is one row per SETTLE_CYCLES+1 cycles; row_ready low holds the presented row and the stimulus indefinitely.
module truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 6,
    parameter int NUM_ROWS      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic [9:0] f_in,
    output logic       row_valid,
    input  logic       row_ready,
    output logic [3:0] row_index,
    output logic [3:0] row_inputs,
    output logic [9:0] row_outputs,
    output logic       busy,
    output logic       done,
    output logic [9:0] signature
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    LAST_ROW   = 4'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, PRESENT, DONE} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_idx;
    logic [3:0]    r_wxyz;
    logic          r_row_valid;
    logic [3:0]    r_row_index;
    logic [3:0]    r_row_inputs;
    logic [9:0]    r_row_outputs;
    logic [9:0]    r_sig;
    logic          w_xfer;

    assign w_xfer = r_row_valid & row_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = DRIVE;
            DRIVE:   if (r_cnt == '0) w_next_state = PRESENT;
            PRESENT: if (w_xfer) w_next_state = (r_idx == LAST_ROW) ? DONE : DRIVE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        // abort also suppresses a start seen in the same cycle
        if (abort) w_next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_wxyz        <= '0;
            r_row_valid   <= 1'b0;
            r_row_index   <= '0;
            r_row_inputs  <= '0;
            r_row_outputs <= '0;
            r_sig         <= '0;
        end else if (abort) begin
            if (r_state != IDLE) begin
                r_row_valid <= 1'b0;
                r_wxyz      <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx  <= '0;
                        r_wxyz <= '0;
                        r_cnt  <= CNT_RELOAD;
                        r_sig  <= '0;
                    end
                end
                DRIVE: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_row_outputs <= f_in;
                        r_row_inputs  <= r_wxyz;
                        r_row_index   <= r_idx;
                        r_row_valid   <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (w_xfer) begin
                        r_sig       <= {r_sig[8:0], r_sig[9]} ^ r_row_outputs;
                        r_row_valid <= 1'b0;
                        // stimulus moves to the next row on the same edge so it is held for the full settle window
                        if (r_idx != LAST_ROW) begin
                            r_idx  <= r_idx + 4'd1;
                            r_wxyz <= r_idx + 4'd1;
                            r_cnt  <= CNT_RELOAD;
                        end
                    end
                end
                DONE:    r_wxyz <= '0;
                default: r_wxyz <= '0;
            endcase
        end
    end

    assign {w, x, y, z}  = r_wxyz;
    assign row_valid     = r_row_valid;
    assign row_index     = r_row_index;
    assign row_inputs    = r_row_inputs;
    assign row_outputs   = r_row_outputs;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign signature     = r_sig;

endmodule
